fibonacci: RTL and testbench
============================

// Module: fibonacci
// PURPOSE
//   Free-running Fibonacci sequence generator on a single clock domain.
//   While f_en is high, emits one term per clock on f_out with f_valid qualifying it.
//   Sequence: 0,1,1,2,3,5,... up to the largest term that fits in WIDTH bits, then restarts at 0.
//   Sits as a leaf datapath block in the slow (10 Hz) domain of the multi-clock system.
// PARAMETERS
//   WIDTH  16  bit width of f_out and of the term registers; sets the wrap point
// PORTS
//   clock    in   1      rising-edge clock, the only clock
//   reset    in   1      asynchronous, active-high reset
//   f_en     in   1      advance enable; one term produced per clock while high
//   f_valid  out  1      high for the cycle(s) in which f_out carries a freshly produced term
//   f_out    out  WIDTH  current Fibonacci term (registered)
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - State: cur (WIDTH bits, term to emit next) and nxt (WIDTH+1 bits, following term).
//   - Reset asserted (async, any time, including mid-sequence): the block clears immediately,
//     without waiting for a clock edge.
//     - cur=0, nxt=1, f_out=0, f_valid=0.
//     - f_en is ignored (may be X) while reset is high.
//   - Rising edge, reset low, f_en=1:
//     - f_out<=cur and f_valid<=1.
//     - If nxt > 2^WIDTH-1 (bit WIDTH set): wrap, cur<=0 and nxt<=1.
//     - Otherwise: cur<=nxt[WIDTH-1:0] and nxt<=cur+nxt, computed at WIDTH+1 bits with no truncation.
//   - Rising edge, reset low, f_en=0 (pause):
//     - f_valid<=0.
//     - f_out, cur and nxt all hold; no term is lost or repeated.
//     - Resuming continues with the next term.
//   - Latency: one clock from sampling f_en=1 to the corresponding term on f_out.
//     - The first term after reset is 0.
//   - Continuous f_en=1: f_valid stays high; one term per clock, no bubbles.
//   - WIDTH=16 period is 25 terms: F0..F24 = 0 .. 46368.
//     - 46368 is followed by 0, 1, 1, 2, ...
//     - 75025 is never emitted, and f_out never shows a truncated value.
//   - Outputs are registered only; no combinational path from f_en to f_out/f_valid.
//   - No internal states beyond the cur/nxt registers and the output registers.
//     - Conceptually the block is IDLE (f_en=0) or RUN (f_en=1); no explicit FSM encoding is required.
//   - Deassertion of reset between clock edges is legal; the first active edge after release
//     with f_en=1 emits 0.
// STRUCTURE
//   - Shared package fib_pkg:
//     - FIB_WIDTH default (16).
//     - FIB_MAX_TERM = 46368 for 16 bits.
//     - FIB_PERIOD = 25, for benches to check against.
//   - Optional sub-module fib_step: combinational cur/nxt -> next cur/nxt plus wrap flag.
//     Everything else (registers, enable, valid) stays in the top module.
// TESTING
//   1. Reset pulse then f_en=1 continuous -> f_out per clock:
//      0,1,1,2,3,5,8,13,21,34,55,89,144; f_valid=1 from the first post-reset edge.
//   2. Run 25 enabled clocks -> 25th term 46368; 26th term 0, then 1,1,2 (wrap).
//      Overflow value 75025 (0x1_2511, truncates to 0x2511) must never appear.
//   3. f_en=1 to term 8, then f_en=0 for 5 clocks -> f_out holds 8, f_valid=0.
//      Re-enable -> next term 13.
//   4. Assert reset asynchronously mid-sequence (f_out=233, between edges) -> f_out=0 and
//      f_valid=0 immediately. Release with f_en=1 -> sequence restarts 0,1,1,2.
//   5. Hold reset high with f_en=1/X for several clocks -> f_out=0, f_valid=0 throughout.
//   6. Alternate f_en 1/0 every clock -> f_valid toggles; emitted terms still 0,1,1,2,3,5 in order.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci generator and its benches.
package fib_pkg;

  localparam int FIB_WIDTH    = 16;
  // Largest term representable in FIB_WIDTH bits and the resulting sequence period.
  localparam int FIB_MAX_TERM = 46368;
  localparam int FIB_PERIOD   = 25;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: advances (cur, nxt), or wraps to (0, 1) once nxt no longer fits in WIDTH bits.
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH:0]   nxt,
  output logic [WIDTH-1:0] cur_next,
  output logic [WIDTH:0]   nxt_next,
  output logic             wrap
);

  always_comb begin
    wrap     = nxt[WIDTH];
    cur_next = nxt[WIDTH-1:0];
    // nxt < 2^WIDTH here, so the sum fits in WIDTH+1 bits without truncation.
    nxt_next = {1'b0, cur} + nxt;
    if (wrap) begin
      cur_next = '0;
      nxt_next = (WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/fibonacci.sv
// Free-running Fibonacci generator: one registered term per enabled clock, wrapping at the WIDTH limit.
module fibonacci
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             f_en,
  output logic             f_valid,
  output logic [WIDTH-1:0] f_out
);

  // Handshake: f_valid=1 marks a cycle in which f_out carries a new term; there is no
  // back-pressure, so the consumer must take every valid term. f_en=0 freezes all state.

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH:0]   nxt_q, nxt_d;
  logic [WIDTH-1:0] f_out_q, f_out_d;
  logic             f_valid_q, f_valid_d;

  logic [WIDTH-1:0] step_cur;
  logic [WIDTH:0]   step_nxt;
  logic             step_wrap;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .cur      (cur_q),
    .nxt      (nxt_q),
    .cur_next (step_cur),
    .nxt_next (step_nxt),
    .wrap     (step_wrap)
  );

  always_comb begin
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    f_out_d   = f_out_q;
    f_valid_d = 1'b0;
    if (f_en) begin
      f_out_d   = cur_q;
      f_valid_d = 1'b1;
      cur_d     = step_cur;
      nxt_d     = step_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_q     <= '0;
      nxt_q     <= (WIDTH+1)'(1);
      f_out_q   <= '0;
      f_valid_q <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      f_out_q   <= f_out_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign f_out   = f_out_q;
  assign f_valid = f_valid_q;

endmodule

// File: tb/tb_fibonacci.sv
// Self-checking bench for fibonacci: scoreboard of expected terms, directed reset/pause/wrap scenarios.
module tb_fibonacci;
  import fib_pkg::*;

  localparam int W = FIB_WIDTH;

  logic         clock;
  logic         reset;
  logic         f_en;
  logic         f_valid;
  logic [W-1:0] f_out;

  int n_checks;
  int n_errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_term;
  int           m_prev;
  int           m_cur;
  int           since_reset;

  fibonacci #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .f_en    (f_en),
    .f_valid (f_valid),
    .f_out   (f_out)
  );

  // Clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: the term after m_cur is m_prev+m_cur unless that would overflow W bits.
  task automatic model_reset();
    m_prev      = -1;
    m_cur       = 0;
    since_reset = 0;
    last_term   = '0;
    exp_q.delete();
  endtask

  task automatic model_emit();
    int nxt;
    exp_q.push_back(W'(m_cur));
    nxt = (m_prev < 0) ? 1 : m_prev + m_cur;
    if (nxt > (1 << W) - 1) begin
      m_prev = -1;
      m_cur  = 0;
    end else begin
      m_prev = m_cur;
      m_cur  = nxt;
    end
  endtask

  // Driver: apply f_en on the falling edge, check #1 after the rising edge.
  task automatic step(input logic en);
    logic [W-1:0] exp;
    @(negedge clock);
    f_en = en;
    if (en) model_emit();
    @(posedge clock);
    #1;
    if (en) begin
      since_reset++;
      check_eq("valid_on", 32'(f_valid), 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check_eq("term", 32'(f_out), 32'(exp));
        last_term = exp;
      end
      check_eq("no_trunc", 32'(f_out == W'(17'h1_2511)), 32'd0);
    end else begin
      check_eq("valid_off", 32'(f_valid), 32'd0);
      check_eq("hold", 32'(f_out), 32'(last_term));
    end
  endtask

  task automatic hold_reset_cycles(input int n);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      f_en = (i % 2 == 0) ? 1'bx : 1'b1;
      @(posedge clock);
      #1;
      check_eq("rst_out", 32'(f_out), 32'd0);
      check_eq("rst_valid", 32'(f_valid), 32'd0);
    end
    #2;
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    f_en  = 1'b0;
    model_reset();
    #3;
    check_eq("por_out", 32'(f_out), 32'd0);
    check_eq("por_valid", 32'(f_valid), 32'd0);
    hold_reset_cycles(2);

    // Continuous run across the wrap point.
    for (int i = 0; i < FIB_PERIOD; i++) step(1'b1);
    check_eq("max_term", 32'(f_out), 32'(FIB_MAX_TERM));
    step(1'b1);
    check_eq("wrap_zero", 32'(f_out), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1);
    check_eq("wrap_2", 32'(f_out), 32'd2);

    // Pause at term 8, then resume with 13.
    hold_reset_cycles(1);
    for (int i = 0; i < 7; i++) step(1'b1);
    check_eq("pause_at", 32'(f_out), 32'd8);
    for (int i = 0; i < 5; i++) step(1'b0);
    step(1'b1);
    check_eq("resume", 32'(f_out), 32'd13);

    // Asynchronous reset between edges while showing 233.
    hold_reset_cycles(1);
    for (int i = 0; i < 14; i++) step(1'b1);
    check_eq("pre_async", 32'(f_out), 32'd233);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_out", 32'(f_out), 32'd0);
    check_eq("async_valid", 32'(f_valid), 32'd0);
    model_reset();
    hold_reset_cycles(4);
    for (int i = 0; i < 4; i++) step(1'b1);
    check_eq("restart_2", 32'(f_out), 32'd2);

    // Alternating enable, then random enable pattern.
    hold_reset_cycles(1);
    for (int i = 0; i < 12; i++) step((i % 2) == 0);
    check_eq("alt_last", 32'(last_term), 32'd5);
    for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)));

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
